// File: rtl/sdram_port_arbiter_if.sv
// Bus bundle between the VGA fetcher / host path, the arbiter and the SDRAM controller.
// Stall counters exist only when SDRAM_ARB_STATS_EN is defined.
interface sdram_port_arbiter_if #(
    parameter int ADDR_W = 25,
    parameter int DATA_W = 16
);
    logic              iA_RD;
    logic [ADDR_W-1:0] iA_ADDR;
    logic              oA_WAIT_REQUEST;
    logic [DATA_W-1:0] oA_RD_DATA;
    logic              oA_RD_DATAVALID;

    logic              iB_RD;
    logic              iB_WR;
    logic [ADDR_W-1:0] iB_ADDR;
    logic [DATA_W-1:0] iB_WDATA;
    logic              oB_WAIT_REQUEST;
    logic [DATA_W-1:0] oB_RD_DATA;
    logic              oB_RD_DATAVALID;

    logic              oM_RD;
    logic              oM_WR;
    logic [ADDR_W-1:0] oM_ADDR;
    logic [DATA_W-1:0] oM_WDATA;
    logic              iM_WAIT_REQUEST;
    logic [DATA_W-1:0] iM_RD_DATA;
    logic              iM_RD_DATAVALID;

    logic              oERR_ORPHAN;
`ifdef SDRAM_ARB_STATS_EN
    logic              iSTATS_CLR;
    logic [15:0]       oA_STALL_CNT;
    logic [15:0]       oB_STALL_CNT;
`endif

    modport slave (
        input  iA_RD, iA_ADDR,
        output oA_WAIT_REQUEST, oA_RD_DATA, oA_RD_DATAVALID,
        input  iB_RD, iB_WR, iB_ADDR, iB_WDATA,
        output oB_WAIT_REQUEST, oB_RD_DATA, oB_RD_DATAVALID,
        output oM_RD, oM_WR, oM_ADDR, oM_WDATA,
        input  iM_WAIT_REQUEST, iM_RD_DATA, iM_RD_DATAVALID,
`ifdef SDRAM_ARB_STATS_EN
        input  iSTATS_CLR,
        output oA_STALL_CNT, oB_STALL_CNT,
`endif
        output oERR_ORPHAN
    );

    modport master (
        output iA_RD, iA_ADDR,
        input  oA_WAIT_REQUEST, oA_RD_DATA, oA_RD_DATAVALID,
        output iB_RD, iB_WR, iB_ADDR, iB_WDATA,
        input  oB_WAIT_REQUEST, oB_RD_DATA, oB_RD_DATAVALID,
        input  oM_RD, oM_WR, oM_ADDR, oM_WDATA,
        output iM_WAIT_REQUEST, iM_RD_DATA, iM_RD_DATAVALID,
`ifdef SDRAM_ARB_STATS_EN
        output iSTATS_CLR,
        input  oA_STALL_CNT, oB_STALL_CNT,
`endif
        input  oERR_ORPHAN
    );
endinterface

// File: rtl/sdram_port_arbiter.sv
// Two-port SDRAM arbiter: A (VGA fetch, read-only, high priority), B (host, rd/wr).
// Optional per-port stall counters under SDRAM_ARB_STATS_EN.
module sdram_port_arbiter #(
    parameter int MAX_PENDING = 8,
    parameter int ADDR_W      = 25,
    parameter int DATA_W      = 16
) (
    input  logic clock,
    input  logic iRST,
    sdram_port_arbiter_if.slave bus
);
    localparam int PW = $clog2(MAX_PENDING);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {IDLE, GNT_A, GNT_B} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     cnt;
    logic [PW-1:0]     wp, rp;
    logic [MAX_PENDING-1:0] tags;
    logic              err;

    logic              full, empty, b_req;
    logic              m_rd, m_wr, a_wait, b_wait;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              accept, push, pop, b_acc, head;

    assign full  = (cnt == CW'(MAX_PENDING));
    assign empty = (cnt == '0);
    assign b_req = bus.iB_RD | bus.iB_WR;

    // Full-mask uses the registered count, so push+pop while full is safe.
    always_comb begin
        m_rd    = 1'b0;
        m_wr    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        a_wait  = 1'b1;
        b_wait  = 1'b1;
        unique case (state)
            GNT_A: begin
                m_rd   = bus.iA_RD & ~full;
                m_addr = bus.iA_ADDR;
                a_wait = bus.iM_WAIT_REQUEST | full;
            end
            GNT_B: begin
                m_rd    = bus.iB_RD & ~full;
                m_wr    = bus.iB_WR;
                m_addr  = bus.iB_ADDR;
                m_wdata = bus.iB_WDATA;
                b_wait  = bus.iM_WAIT_REQUEST | (full & bus.iB_RD);
            end
            default: ;
        endcase
    end

    assign accept = (m_rd | m_wr) & ~bus.iM_WAIT_REQUEST;
    assign push   = m_rd & ~bus.iM_WAIT_REQUEST;
    assign pop    = bus.iM_RD_DATAVALID & ~empty;
    assign b_acc  = (state == GNT_B) & accept;
    assign head   = tags[rp];

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (bus.iA_RD)  state_nx = GNT_A;
                else if (b_req) state_nx = GNT_B;
            end
            GNT_A: begin
                if (!bus.iA_RD) state_nx = b_req ? GNT_B : IDLE;
            end
            GNT_B: begin
                if (bus.iA_RD && (b_acc || !b_req)) state_nx = GNT_A;
                else if (!b_req)                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge iRST) begin
        if (iRST) begin
            state <= IDLE;
            cnt   <= '0;
            wp    <= '0;
            rp    <= '0;
            tags  <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt + CW'(push) - CW'(pop);
            if (push) begin
                tags[wp] <= (state == GNT_B);
                wp       <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            if (bus.iM_RD_DATAVALID && empty) err <= 1'b1;
        end
    end

    assign bus.oM_RD           = m_rd;
    assign bus.oM_WR           = m_wr;
    assign bus.oM_ADDR         = m_addr;
    assign bus.oM_WDATA        = m_wdata;
    assign bus.oA_WAIT_REQUEST = a_wait;
    assign bus.oB_WAIT_REQUEST = b_wait;
    assign bus.oA_RD_DATA      = bus.iM_RD_DATA;
    assign bus.oB_RD_DATA      = bus.iM_RD_DATA;
    assign bus.oA_RD_DATAVALID = bus.iM_RD_DATAVALID & ~empty & ~head;
    assign bus.oB_RD_DATAVALID = bus.iM_RD_DATAVALID & ~empty & head;
    assign bus.oERR_ORPHAN     = err;

`ifdef SDRAM_ARB_STATS_EN
    logic [15:0] a_stall, b_stall;

    always_ff @(posedge clock or posedge iRST) begin
        if (iRST) begin
            a_stall <= '0;
            b_stall <= '0;
        end else if (bus.iSTATS_CLR) begin
            a_stall <= '0;
            b_stall <= '0;
        end else begin
            if (bus.iA_RD && a_wait && a_stall != 16'hFFFF)
                a_stall <= a_stall + 16'd1;
            if (b_req && b_wait && b_stall != 16'hFFFF)
                b_stall <= b_stall + 16'd1;
        end
    end

    assign bus.oA_STALL_CNT = a_stall;
    assign bus.oB_STALL_CNT = b_stall;
`endif
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter with a small SDRAM responder model.
// Stall-counter checks run only when SDRAM_ARB_STATS_EN is defined.
module tb_sdram_port_arbiter;
    localparam int AW = 25;
    localparam int DW = 16;
    localparam int MP = 8;

    logic clock = 1'b0;
    logic iRST  = 1'b1;

    sdram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

    sdram_port_arbiter #(
        .MAX_PENDING(MP), .ADDR_W(AW), .DATA_W(DW)
    ) dut (
        .clock(clock),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        bit            port;
        logic [DW-1:0] data;
    } exp_t;

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } ret_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q[$];
    ret_t ret_q[$];
    logic [AW+DW-1:0] wr_log[$];
    int   lat = 3;
    bit   withhold = 1'b0;
    int   cyc = 0;
    int   delivered = 0;

    function automatic logic [DW-1:0] fdat(input logic [AW-1:0] a);
        return a[DW-1:0] ^ 16'hA5C3;
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // SDRAM responder: accepts at negedge, returns data lat cycles later
    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        if (bus.oM_RD && !bus.iM_WAIT_REQUEST)
            ret_q.push_back('{cyc + lat, fdat(bus.oM_ADDR)});
        if (bus.oM_WR && !bus.iM_WAIT_REQUEST)
            wr_log.push_back({bus.oM_ADDR, bus.oM_WDATA});
    end

    always @(posedge clock) begin
        ret_t r;
        #2;
        bus.iM_RD_DATAVALID = 1'b0;
        if (!withhold && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            bus.iM_RD_DATA      = r.data;
            bus.iM_RD_DATAVALID = 1'b1;
            delivered++;
        end
    end

    // Monitor: every port valid must match the head of the scoreboard
    always @(negedge clock) begin
        exp_t e;
        logic [DW-1:0] d;
        if (bus.oA_RD_DATAVALID || bus.oB_RD_DATAVALID) begin
            n_cmp++;
            d = bus.oB_RD_DATAVALID ? bus.oB_RD_DATA : bus.oA_RD_DATA;
            if (bus.oA_RD_DATAVALID && bus.oB_RD_DATAVALID) begin
                n_bad++;
                $display("FAIL rd_both_valid: got A=1 B=1 want one");
            end else if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL rd_unexpected: got valid port %0d data %0h want none",
                         bus.oB_RD_DATAVALID, d);
            end else begin
                e = exp_q.pop_front();
                if (bus.oB_RD_DATAVALID !== e.port || d !== e.data) begin
                    n_bad++;
                    $display("FAIL rd_return: got port %0d data %0h want port %0d data %0h",
                             bus.oB_RD_DATAVALID, d, e.port, e.data);
                end
            end
        end
    end

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() > 0; i++) tick();
        chk("drain_left", exp_q.size(), 0);
    endtask

    task automatic a_reads(input logic [AW-1:0] start, input int n);
        logic [AW-1:0] addr;
        int k;
        int guard;
        addr = start;
        k = 0;
        guard = 0;
        bus.iA_ADDR = addr;
        bus.iA_RD   = 1'b1;
        while (k < n && guard < 5000) begin
            guard++;
            #1;
            if (!bus.oA_WAIT_REQUEST) begin
                exp_q.push_back('{1'b0, fdat(addr)});
                k++;
                tick();
                addr = addr + 1'b1;
                bus.iA_ADDR = addr;
            end else begin
                tick();
            end
        end
        bus.iA_RD = 1'b0;
        chk("a_reads_issued", k, n);
    endtask

    initial begin
        int d0;
        bus.iA_RD = 0; bus.iA_ADDR = '0;
        bus.iB_RD = 0; bus.iB_WR = 0; bus.iB_ADDR = '0; bus.iB_WDATA = '0;
        bus.iM_WAIT_REQUEST = 0;
`ifdef SDRAM_ARB_STATS_EN
        bus.iSTATS_CLR = 0;
`endif
        tick();
        tick();
        chk("rst_m_rd", bus.oM_RD, 0);
        chk("rst_m_wr", bus.oM_WR, 0);
        chk("rst_m_addr", bus.oM_ADDR, 0);
        chk("rst_m_wdata", bus.oM_WDATA, 0);
        chk("rst_a_wait", bus.oA_WAIT_REQUEST, 1);
        chk("rst_b_wait", bus.oB_WAIT_REQUEST, 1);
        chk("rst_a_dv", bus.oA_RD_DATAVALID, 0);
        chk("rst_b_dv", bus.oB_RD_DATAVALID, 0);
        chk("rst_orphan", bus.oERR_ORPHAN, 0);
        iRST = 1'b0;
        tick();

        // A-only burst of 512
        lat = 3;
        bus.iA_RD = 1'b1;
        bus.iA_ADDR = 25'h200;
        #1;
        chk("t1_idle_no_rd", bus.oM_RD, 0);
        tick();
        chk("t1_first_rd", bus.oM_RD, 1);
        chk("t1_first_addr", bus.oM_ADDR, 32'h200);
        a_reads(25'h200, 512);
        drain();

        // B write stalled; A must not preempt it
        bus.iM_WAIT_REQUEST = 1'b1;
        bus.iB_WR = 1'b1;
        bus.iB_ADDR = 25'h55;
        bus.iB_WDATA = 16'hBEEF;
        tick();
        #1;
        chk("t2_b_on_master", bus.oM_WR, 1);
        chk("t2_b_addr", bus.oM_ADDR, 32'h55);
        chk("t2_b_wait_stall", bus.oB_WAIT_REQUEST, 1);
        tick();
        bus.iA_RD = 1'b1;
        bus.iA_ADDR = 25'h30;
        #1;
        chk("t2_a_blocked", bus.oA_WAIT_REQUEST, 1);
        chk("t2_no_preempt", bus.oM_WR, 1);
        tick();
        tick();
        #1;
        chk("t2_still_b", bus.oM_ADDR, 32'h55);
        tick();
        bus.iM_WAIT_REQUEST = 1'b0;
        #1;
        chk("t2_b_accept", bus.oB_WAIT_REQUEST, 0);
        tick();
        bus.iB_ADDR = 25'h56;
        bus.iB_WDATA = 16'h1234;
        #1;
        chk("t2_gnt_a_rd", bus.oM_RD, 1);
        chk("t2_gnt_a_addr", bus.oM_ADDR, 32'h30);
        chk("t2_b_wait_in_a", bus.oB_WAIT_REQUEST, 1);
        exp_q.push_back('{1'b0, fdat(25'h30)});
        tick();
        bus.iA_RD = 1'b0;
        #1;
        chk("t2_b_wait_a_low", bus.oB_WAIT_REQUEST, 1);
        chk("t2_no_rd_a_low", bus.oM_RD, 0);
        tick();
        #1;
        chk("t2_b_regrant_wr", bus.oM_WR, 1);
        chk("t2_b_wdata", bus.oM_WDATA, 32'h1234);
        chk("t2_b_wait_low", bus.oB_WAIT_REQUEST, 0);
        tick();
        bus.iB_WR = 1'b0;
        drain();
        chk("t2_wr_count", wr_log.size(), 2);
        if (wr_log.size() == 2) begin
            chk("t2_wr0", wr_log[0], {25'h55, 16'hBEEF});
            chk("t2_wr1", wr_log[1], {25'h56, 16'h1234});
        end

        // Interleaved B, A, A reads
        lat = 5;
        bus.iB_RD = 1'b1;
        bus.iB_ADDR = 25'h10;
        tick();
        #1;
        chk("t3_b_go", bus.oB_WAIT_REQUEST, 0);
        exp_q.push_back('{1'b1, fdat(25'h10)});
        bus.iA_RD = 1'b1;
        bus.iA_ADDR = 25'h20;
        tick();
        bus.iB_RD = 1'b0;
        #1;
        chk("t3_a0_go", bus.oA_WAIT_REQUEST, 0);
        exp_q.push_back('{1'b0, fdat(25'h20)});
        tick();
        bus.iA_ADDR = 25'h21;
        #1;
        chk("t3_a1_go", bus.oA_WAIT_REQUEST, 0);
        exp_q.push_back('{1'b0, fdat(25'h21)});
        tick();
        bus.iA_RD = 1'b0;
        drain();

        // Full mask with data withheld
        withhold = 1'b1;
        lat = 1;
        a_reads(25'h300, MP);
        bus.iA_RD = 1'b1;
        bus.iA_ADDR = 25'h308;
        #1;
        chk("t4_masked_rd", bus.oM_RD, 0);
        chk("t4_masked_wait", bus.oA_WAIT_REQUEST, 1);
        tick();
        #1;
        chk("t4_still_masked", bus.oM_RD, 0);
        withhold = 1'b0;
        tick();
        #2;
        chk("t4_dv_seen", bus.oA_RD_DATAVALID, 1);
        chk("t4_mask_during_dv", bus.oM_RD, 0);
        tick();
        #1;
        chk("t4_unmask", bus.oM_RD, 1);
        exp_q.push_back('{1'b0, fdat(25'h308)});
        tick();
        bus.iA_RD = 1'b0;
        drain();

        // Reset with 3 reads pending, then late data are orphans
        withhold = 1'b1;
        a_reads(25'h400, 3);
        tick();
        iRST = 1'b1;
        exp_q.delete();
        #1;
        chk("t5_rst_a_wait", bus.oA_WAIT_REQUEST, 1);
        chk("t5_rst_orphan", bus.oERR_ORPHAN, 0);
        tick();
        iRST = 1'b0;
        d0 = delivered;
        withhold = 1'b0;
        repeat (8) tick();
        chk("t5_delivered", delivered - d0, 3);
        chk("t5_orphan_flag", bus.oERR_ORPHAN, 1);
        repeat (3) tick();
        chk("t5_orphan_sticky", bus.oERR_ORPHAN, 1);

`ifdef SDRAM_ARB_STATS_EN
        bus.iM_WAIT_REQUEST = 1'b1;
        bus.iA_RD = 1'b1;
        bus.iA_ADDR = 25'h500;
        repeat (5) tick();
        chk("t6_a_stall_5", bus.oA_STALL_CNT, 5);
        repeat (69995) tick();
        chk("t6_a_stall_sat", bus.oA_STALL_CNT, 16'hFFFF);
        chk("t6_b_stall_idle", bus.oB_STALL_CNT, 0);
        bus.iSTATS_CLR = 1'b1;
        tick();
        bus.iSTATS_CLR = 1'b0;
        chk("t6_a_stall_clr", bus.oA_STALL_CNT, 0);
        bus.iA_RD = 1'b0;
        bus.iM_WAIT_REQUEST = 1'b0;
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller master port (Avalon-style: wait-request and read-data-valid) between two requesters.
- Port A is the VGA line fetcher: read-only, highest priority.
- Port B is the host frame-upload/readback path: read and write, low priority.
- Tracks outstanding reads so each returned word reaches the requester that issued it. Sits between the line fetcher/host logic and the SDRAM controller.

Parameters:
- MAX_PENDING, 8: maximum reads accepted by SDRAM whose data has not yet returned (power of 2, 2..16).
- ADDR_W, 25: SDRAM word-address width.
- DATA_W, 16: SDRAM data width.

Ports:
- clock  in  1  system clock; all logic on posedge.
- iRST  in  1  reset, asynchronous, active-high.
- iA_RD  in  1  port A read request; held while oA_WAIT_REQUEST=1.
- iA_ADDR  in  ADDR_W  port A address.
- oA_WAIT_REQUEST  out  1  port A command not accepted this cycle.
- oA_RD_DATA  out  DATA_W  port A read data.
- oA_RD_DATAVALID  out  1  port A read data valid.
- iB_RD  in  1  port B read request.
- iB_WR  in  1  port B write request; iB_RD and iB_WR are never both 1.
- iB_ADDR  in  ADDR_W  port B address.
- iB_WDATA  in  DATA_W  port B write data.
- oB_WAIT_REQUEST  out  1  port B command not accepted.
- oB_RD_DATA  out  DATA_W  port B read data.
- oB_RD_DATAVALID  out  1  port B read data valid.
- oM_RD  out  1  master read.
- oM_WR  out  1  master write.
- oM_ADDR  out  ADDR_W  master address.
- oM_WDATA  out  DATA_W  master write data.
- iM_WAIT_REQUEST  in  1  SDRAM stall.
- iM_RD_DATA  in  DATA_W  SDRAM read data.
- iM_RD_DATAVALID  in  1  SDRAM read data valid.
- oERR_ORPHAN  out  1  sticky flag: data-valid received with no pending read.

Behaviour:
- Reset values: grant=IDLE, tag queue empty, pending count 0.
  - oM_RD=0, oM_WR=0, oM_ADDR=0, oM_WDATA=0.
  - oA_WAIT_REQUEST=1, oB_WAIT_REQUEST=1.
  - Both data-valid outputs 0; oERR_ORPHAN=0.
- Reset mid-operation discards all pending tags. Data-valids arriving after reset are orphans and set oERR_ORPHAN.
- Grant state machine (registered), with states IDLE, GNT_A and GNT_B:
  - IDLE: if iA_RD, go to GNT_A. Else if iB_RD|iB_WR, go to GNT_B. Else stay.
  - GNT_A: stay while iA_RD. When iA_RD=0, go to GNT_B if B is requesting, else IDLE.
  - GNT_B: if iA_RD and (B command accepted this cycle, or B not requesting), go to GNT_A. Else if B is not requesting, go to IDLE. Else stay.
  - A never preempts a B command that is still stalled.
- Arbitration latency: a request arriving in IDLE is granted on the next cycle. There is no bubble on a handoff that happens at a transfer boundary.
- Master outputs are a combinational mux of the granted port. In IDLE, oM_RD and oM_WR are 0 and oM_ADDR and oM_WDATA hold 0.
- Non-granted ports always see WAIT_REQUEST=1. The granted port sees iM_WAIT_REQUEST or'd with the full-mask.
- Acceptance: a command is accepted when (oM_RD|oM_WR)=1 and iM_WAIT_REQUEST=0.
- Full-mask: when pending count == MAX_PENDING, oM_RD is forced to 0 and the granted reader sees wait=1. Writes are unaffected.
- Tag queue:
  - 1-bit FIFO of depth MAX_PENDING.
  - Push the granted port ID (0=A, 1=B) on every accepted read.
  - Pop on every iM_RD_DATAVALID.
  - A push and a pop in the same cycle leave the count unchanged. This is legal even when full, because the mask is evaluated on the registered count.
- Read return:
  - oA_RD_DATA and oB_RD_DATA both equal iM_RD_DATA combinationally.
  - oA_RD_DATAVALID = iM_RD_DATAVALID & !empty & head==0.
  - oB_RD_DATAVALID = iM_RD_DATAVALID & !empty & head==1.
  - Zero latency added.
- Orphan: iM_RD_DATAVALID while the queue is empty is dropped (no valid on either port) and sets oERR_ORPHAN until reset.
- Pending count width is clog2(MAX_PENDING)+1. Queue pointers wrap modulo MAX_PENDING.

Optional Feature:
- Macro: SDRAM_ARB_STATS_EN.
- When defined, adds:
  - Input iSTATS_CLR.
  - Output oA_STALL_CNT[15:0]: saturating count of cycles with iA_RD=1 and oA_WAIT_REQUEST=1.
  - Output oB_STALL_CNT[15:0]: same for port B.
  - Counters reset to 0 on iRST, clear synchronously on iSTATS_CLR, and hold at 16'hFFFF.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- A-only burst:
  - Stimulus: iA_RD held for 512 reads from 0x000200, SDRAM returns data 3 cycles later with no waits.
  - Required: 512 oA_RD_DATAVALID in order, no B valids, first oM_RD one cycle after iA_RD rises.
- Priority and non-preemption:
  - Stimulus: B write stalled by iM_WAIT_REQUEST=1 for 4 cycles; A requests in cycle 2.
  - Required: B write stays on the master until accepted; GNT_A starts the next cycle; B then sees wait=1 until iA_RD drops.
- Interleaved reads:
  - Stimulus: B reads 0x10, then A reads 0x20, 0x21, with data returned 5 cycles late.
  - Required: tags return in order B, A, A with datavalid on the matching port only.
- Full mask:
  - Stimulus: MAX_PENDING=8, 8 A reads accepted, data withheld.
  - Required: 9th read held, oM_RD=0; on the first data-valid, oM_RD=1 in the next cycle.
- Orphan and reset:
  - Stimulus: assert iRST with 3 reads pending, then deliver 3 data-valids.
  - Required: no port valids, oERR_ORPHAN=1.
- Stats (SDRAM_ARB_STATS_EN):
  - Stimulus: A stalled for 70000 cycles.
  - Required: oA_STALL_CNT=16'hFFFF; iSTATS_CLR returns it to 0.
